// File: rtl/excep_recovery_ctrl.sv
// Precise-exception recovery sequencer: picks the oldest excepting retirement slot,
// flushes, drains memory, restores RAT/free list from the ARAT snapshot, then redirects fetch.
module excep_recovery_ctrl #(
  parameter int              P_W         = 5,
  parameter int              R_NUM       = 8,
  parameter int              FL_W        = 32,
  parameter int              PC_W        = 32,
  parameter logic [PC_W-1:0] EXCEP_ENTRY = 32'h0000_0100,
  parameter int              DRAIN_MAX   = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [2:0]                  ready_ret,
  input  logic [2:0]                  excep_ret,
  input  logic [2:0][PC_W-1:0]        pc_ret,
  input  logic                        mem_busy,
  input  logic [R_NUM-1:0][P_W-1:0]   ARAT_P_list,
  input  logic [FL_W-1:0]             ARAT_freelist,
  output logic                        flush,
  output logic                        stall,
  output logic                        rat_we,
  output logic [$clog2(R_NUM)-1:0]    rat_idx,
  output logic [P_W-1:0]              rat_data,
  output logic                        fl_load,
  output logic [FL_W-1:0]             fl_data,
  output logic                        redirect_valid,
  output logic [PC_W-1:0]             redirect_pc,
  output logic [PC_W-1:0]             epc,
  output logic                        drain_timeout,
  output logic                        busy
);

  localparam int IDX_W = $clog2(R_NUM);
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_DRAIN,
    S_RESTORE,
    S_FREELIST,
    S_REDIRECT
  } state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [PC_W-1:0]             epc_q, epc_d;
  logic                        tmo_q, tmo_d;
  logic [R_NUM-1:0][P_W-1:0]   snap_q, snap_d;
  logic [FL_W-1:0]             snapfl_q, snapfl_d;

  logic [2:0]                  exc_oh;
  logic [PC_W-1:0]             exc_pc;
  logic                        drain_done;

  // A slot only counts if every older slot retires cleanly this cycle.
  function automatic logic [2:0] first_exc_oh(input logic [2:0] rdy, input logic [2:0] exc);
    logic [2:0] oh;
    oh[0] = rdy[0] & exc[0];
    oh[1] = rdy[0] & ~exc[0] & rdy[1] & exc[1];
    oh[2] = rdy[0] & ~exc[0] & rdy[1] & ~exc[1] & rdy[2] & exc[2];
    return oh;
  endfunction

  always_comb begin
    exc_oh = first_exc_oh(ready_ret, excep_ret);
    exc_pc = '0;
    for (int k = 0; k < 3; k++) begin
      if (exc_oh[k]) exc_pc = pc_ret[k];
    end
  end

  assign drain_done = !mem_busy || (cnt_q == CNT_W'(DRAIN_MAX));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    epc_d    = epc_q;
    tmo_d    = tmo_q;
    snap_d   = snap_q;
    snapfl_d = snapfl_q;
    case (state_q)
      S_IDLE: begin
        if (|exc_oh) begin
          epc_d   = exc_pc;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        cnt_d   = '0;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_done) begin
          if (mem_busy) tmo_d = 1'b1;
          snap_d   = ARAT_P_list;
          snapfl_d = ARAT_freelist;
          idx_d    = '0;
          state_d  = S_RESTORE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESTORE: begin
        // idx parks on the last entry so it never wraps while still restoring.
        if (idx_q == IDX_W'(R_NUM - 1)) begin
          state_d = S_FREELIST;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_FREELIST: state_d = S_REDIRECT;
      S_REDIRECT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      epc_q    <= '0;
      tmo_q    <= 1'b0;
      snap_q   <= '0;
      snapfl_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      epc_q    <= epc_d;
      tmo_q    <= tmo_d;
      snap_q   <= snap_d;
      snapfl_q <= snapfl_d;
    end
  end

  // Outputs decode registered state only; data buses are zero while their enables are low.
  always_comb begin
    flush          = 1'b0;
    rat_we         = 1'b0;
    rat_idx        = '0;
    rat_data       = '0;
    fl_load        = 1'b0;
    fl_data        = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state_q)
      S_FLUSH:    flush = 1'b1;
      S_RESTORE: begin
        rat_we   = 1'b1;
        rat_idx  = idx_q;
        rat_data = snap_q[idx_q];
      end
      S_FREELIST: begin
        fl_load = 1'b1;
        fl_data = snapfl_q;
      end
      S_REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = EXCEP_ENTRY;
      end
      default: ;
    endcase
    stall         = (state_q != S_IDLE);
    busy          = (state_q != S_IDLE);
    epc           = epc_q;
    drain_timeout = tmo_q;
  end

endmodule

// File: tb/tb_excep_recovery_ctrl.sv
// Randomized self-checking bench for excep_recovery_ctrl; expectations come from a
// transaction-level model of the recovery timeline.
module tb_excep_recovery_ctrl;

  localparam int DRAIN_MAX = 255;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        ready_ret;
  logic [2:0]        excep_ret;
  logic [2:0][31:0]  pc_ret;
  logic              mem_busy;
  logic [7:0][4:0]   ARAT_P_list;
  logic [31:0]       ARAT_freelist;
  logic              flush, stall, rat_we, fl_load, redirect_valid, drain_timeout, busy;
  logic [2:0]        rat_idx;
  logic [4:0]        rat_data;
  logic [31:0]       fl_data, redirect_pc, epc;

  excep_recovery_ctrl dut (
    .clk(clk), .rst(rst),
    .ready_ret(ready_ret), .excep_ret(excep_ret), .pc_ret(pc_ret),
    .mem_busy(mem_busy), .ARAT_P_list(ARAT_P_list), .ARAT_freelist(ARAT_freelist),
    .flush(flush), .stall(stall), .rat_we(rat_we), .rat_idx(rat_idx), .rat_data(rat_data),
    .fl_load(fl_load), .fl_data(fl_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .epc(epc), .drain_timeout(drain_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_epc = '0;
  logic        m_tmo = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string ph, input logic e_flush, input logic e_stall,
                         input logic e_we, input logic [2:0] e_idx, input logic [4:0] e_data,
                         input logic e_fl, input logic [31:0] e_fld,
                         input logic e_rv, input logic [31:0] e_rpc);
    chk({ph, ".flush"},    64'(flush),          64'(e_flush));
    chk({ph, ".stall"},    64'(stall),          64'(e_stall));
    chk({ph, ".busy"},     64'(busy),           64'(e_stall));
    chk({ph, ".rat_we"},   64'(rat_we),         64'(e_we));
    chk({ph, ".rat_idx"},  64'(rat_idx),        64'(e_idx));
    chk({ph, ".rat_data"}, 64'(rat_data),       64'(e_data));
    chk({ph, ".fl_load"},  64'(fl_load),        64'(e_fl));
    chk({ph, ".fl_data"},  64'(fl_data),        64'(e_fld));
    chk({ph, ".redir_v"},  64'(redirect_valid), 64'(e_rv));
    chk({ph, ".redir_pc"}, 64'(redirect_pc),    64'(e_rpc));
    chk({ph, ".epc"},      64'(epc),            64'(m_epc));
    chk({ph, ".timeout"},  64'(drain_timeout),  64'(m_tmo));
  endtask

  task automatic chk_idle(input string ph);
    chk_all(ph, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Oldest-first rule: stop at the first slot that is not retiring or that excepts.
  function automatic int first_exc(input logic [2:0] r, input logic [2:0] e);
    for (int k = 0; k < 3; k++) begin
      if (!r[k]) return -1;
      if (e[k]) return k;
    end
    return -1;
  endfunction

  task automatic drive_noise();
    ready_ret = 3'($urandom);
    excep_ret = 3'($urandom);
    for (int k = 0; k < 3; k++) pc_ret[k] = $urandom;
  endtask

  task automatic rand_arat();
    for (int i = 0; i < 8; i++) ARAT_P_list[i] = 5'($urandom);
    ARAT_freelist = $urandom;
  endtask

  task automatic quiet();
    ready_ret = '0;
    excep_ret = '0;
    mem_busy  = 1'b0;
  endtask

  task automatic run_recovery(input logic [2:0] r, input logic [2:0] e,
                              input logic [2:0][31:0] pcs, input int busy_n,
                              input bit snap_mode, input int rst_at);
    int              k;
    int              d_exit;
    logic [7:0][4:0] s_map;
    logic [31:0]     s_fl;
    s_map = '0;
    s_fl  = '0;
    cyc();
    chk_idle("pre");
    ready_ret = r;
    excep_ret = e;
    pc_ret    = pcs;
    mem_busy  = 1'($urandom);
    rand_arat();
    k = first_exc(r, e);
    if (k >= 0) m_epc = pcs[k];
    cyc();
    chk_all("flush", 1'b1, 1'b1, 1'b0, 3'd0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    drive_noise();
    mem_busy = 1'($urandom);
    rand_arat();
    d_exit = (busy_n < DRAIN_MAX) ? busy_n : DRAIN_MAX;
    for (int i = 0; i <= d_exit; i++) begin
      cyc();
      chk_all("drain", 1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      drive_noise();
      mem_busy = (i < busy_n);
      if (i == d_exit && snap_mode) begin
        for (int j = 0; j < 8; j++) ARAT_P_list[j] = 5'(j + 8);
        ARAT_freelist = 32'hFFFF_0000;
      end else begin
        rand_arat();
      end
      if (i == d_exit) begin
        s_map = ARAT_P_list;
        s_fl  = ARAT_freelist;
      end
    end
    if (busy_n > DRAIN_MAX) m_tmo = 1'b1;
    for (int rr = 0; rr < 8; rr++) begin
      cyc();
      if (rr == rst_at) begin
        rst = 1'b1;
        #1;
        m_epc = '0;
        m_tmo = 1'b0;
        chk_idle("rst_async");
        quiet();
        cyc();
        chk_idle("rst_hold");
        rst = 1'b0;
        for (int w = 0; w < 3; w++) begin
          cyc();
          chk_idle("post_rst");
        end
        return;
      end
      chk_all("restore", 1'b0, 1'b1, 1'b1, 3'(rr), s_map[rr], 1'b0, 32'd0, 1'b0, 32'd0);
      drive_noise();
      mem_busy = 1'($urandom);
      if (snap_mode) begin
        ARAT_P_list   = '0;
        ARAT_freelist = '0;
      end else begin
        rand_arat();
      end
    end
    cyc();
    chk_all("freelist", 1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 1'b1, s_fl, 1'b0, 32'd0);
    drive_noise();
    cyc();
    chk_all("redirect", 1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 1'b0, 32'd0, 1'b1, 32'h0000_0100);
    quiet();
    cyc();
    chk_idle("post");
  endtask

  task automatic rand_run(input int busy_n, input bit snap_mode, input int rst_at);
    logic [2:0]       r, e;
    logic [2:0][31:0] pcs;
    int               k;
    k = $urandom_range(0, 2);
    r = 3'($urandom);
    e = 3'($urandom);
    for (int j = 0; j < k; j++) begin
      r[j] = 1'b1;
      e[j] = 1'b0;
    end
    r[k] = 1'b1;
    e[k] = 1'b1;
    for (int j = 0; j < 3; j++) pcs[j] = $urandom;
    run_recovery(r, e, pcs, busy_n, snap_mode, rst_at);
  endtask

  task automatic idle_noexc(input int n);
    logic [2:0] r, e;
    for (int i = 0; i < n; i++) begin
      cyc();
      chk_idle("idle");
      r = 3'($urandom);
      e = 3'($urandom);
      for (int t = 0; t < 20 && first_exc(r, e) >= 0; t++) begin
        r = 3'($urandom);
        e = 3'($urandom);
      end
      if (first_exc(r, e) >= 0) r = 3'b000;
      ready_ret = r;
      excep_ret = e;
      for (int k = 0; k < 3; k++) pc_ret[k] = $urandom;
      mem_busy = 1'($urandom);
      rand_arat();
    end
    cyc();
    chk_idle("idle_end");
    quiet();
  endtask

  logic [2:0][31:0] pcs0;

  initial begin
    rst = 1'b1;
    quiet();
    pc_ret        = '0;
    ARAT_P_list   = '0;
    ARAT_freelist = '0;
    #1;
    chk_idle("reset");
    cyc();
    cyc();
    chk_idle("reset_hold");
    rst = 1'b0;

    // Slot 0 not retiring gates the slot-1 exception.
    cyc();
    chk_idle("gate_pre");
    ready_ret = 3'b110;
    excep_ret = 3'b010;
    pc_ret[1] = 32'h0000_0044;
    cyc();
    chk_idle("gated");
    cyc();
    chk_idle("gated2");
    quiet();

    pcs0[0] = 32'h0000_0014;
    pcs0[1] = 32'h0000_001C;
    pcs0[2] = 32'h0000_0024;
    run_recovery(3'b111, 3'b110, pcs0, 0, 1'b0, -1);
    rand_run(5, 1'b0, -1);
    rand_run(0, 1'b1, -1);
    rand_run(300, 1'b0, -1);
    rand_run(2, 1'b0, -1);
    rand_run(0, 1'b0, 3);
    rand_run(0, 1'b0, -1);

    for (int t = 0; t < 12; t++) begin
      idle_noexc($urandom_range(1, 4));
      rand_run($urandom_range(0, 12), 1'($urandom), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
